// File: rtl/mem_pkg.sv
// Shared definitions for the memory-side responders: FSM encoding, bus widths
// and the access check used by both the data and instruction paths.
package mem_pkg;

    localparam int WORD_W  = 32;
    localparam int WSTRB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Misaligned word address or word index past the end of storage.
    function automatic logic access_err(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module sram_1rw
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic               re,
    input  logic [AW-1:0]      addr,
    input  logic [WSTRB_W-1:0] wstrb,
    input  logic [WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]  rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // NOTE: storage has no reset; contents must survive a responder reset and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WSTRB_W; i++) begin
                if (wstrb[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: valid/ready request and response channels in front
// of a word RAM, with a fixed wait-state count and access-error reporting.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [WORD_W-1:0]  req_wdata,
    input  logic [WSTRB_W-1:0] req_wstrb,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WORD_W-1:0]  resp_rdata,
    output logic               resp_err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_load_q, resp_load_d;

    logic              accept, to_resp, addr_err, we_sel, mem_we, mem_re;
    logic [31:0]       addr_sel;
    logic [WORD_W-1:0] mem_rdata;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // In IDLE the live request drives the RAM (stores commit at the accept edge);
    // afterwards the latched request does. Store data is never needed past that edge.
    assign addr_sel = (state_q == ST_IDLE) ? req_addr : addr_q;
    assign we_sel   = (state_q == ST_IDLE) ? req_we : we_q;
    assign addr_err = access_err(addr_sel, DEPTH_WORDS);

    assign to_resp = ((state_q == ST_IDLE) && accept && (LATENCY == 0)) ||
                     ((state_q == ST_WAIT) && (cnt_q == LAT_LAST));
    assign mem_we  = accept && req_we && !addr_err;
    assign mem_re  = to_resp && !we_sel && !addr_err;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_load_d  = resp_load_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                if (accept) state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_load_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (to_resp) begin
            resp_valid_d = 1'b1;
            resp_err_d   = addr_err;
            resp_load_d  = !we_sel && !addr_err;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_load_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_load_q  <= resp_load_d;
            if (accept) begin
                we_q   <= req_we;
                addr_q <= req_addr;
            end
        end
    end

    sram_1rw #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_sram (
        .clk  (clk),
        .we   (mem_we),
        .re   (mem_re),
        .addr (addr_sel[AW+1:2]),
        .wstrb(req_wstrb),
        .wdata(req_wdata),
        .rdata(mem_rdata)
    );

    // RAM read register is not reset, so load data is gated by the response flag.
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_load_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic against a byte-level memory model.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One complete transaction; lat = edges from accept to first visible response, -1 on timeout.
    task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int bp,
                            output logic [31:0] rdata, output logic err, output int lat,
                            output int acc_cyc);
        int w;
        w = 0;
        while (!req_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        resp_ready = (bp == 0);
        @(posedge clk); #1;
        acc_cyc = cyc;
        req_valid = 1'b0; req_we = $urandom; req_addr = $urandom; req_wdata = $urandom; req_wstrb = $urandom;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        rdata = resp_rdata; err = resp_err;
        if (!resp_valid) lat = -1;
        repeat (bp) begin @(posedge clk); #1; end
        resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1; reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({req_ready, resp_valid, resp_err, resp_rdata} !== {3'b100, 32'h0}) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: got rdy=%b vld=%b err=%b rdata=%h, need rdy=1 vld=0 err=0 rdata=0",
                         i, req_ready, resp_valid, resp_err, resp_rdata);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat, ac;
        transact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, ac);
        checks++;
        if ({er, rd} !== 33'h0 || lat !== LAT) begin
            errors++;
            $display("FAIL sw_resp: got err=%b rdata=%h lat=%0d, need err=0 rdata=0 lat=%0d", er, rd, lat, LAT);
        end
        transact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, ac);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL lw_resp: got err=%b rdata=%h lat=%0d, need err=0 rdata=deadbeef lat=%0d", er, rd, lat, LAT);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er; int lat, ac;
        transact(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, ac);
        transact(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, rd, er, lat, ac);
        transact(1'b1, 32'h20, 32'h99999999, 4'h0, 0, rd, er, lat, ac);
        transact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, ac);
        checks++;
        if (rd !== 32'h11BB33DD || er !== 1'b0) begin
            errors++;
            $display("FAIL byte_lanes: got rdata=%h err=%b, need 11bb33dd err=0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, ac;
        transact(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, ac);
        transact(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat, ac);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL lw_misaligned: got err=%b rdata=%h, need err=1 rdata=0", er, rd);
        end
        transact(1'b1, 32'h1000, 32'h55555555, 4'hF, 0, rd, er, lat, ac);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL sw_range: got err=%b rdata=%h, need err=1 rdata=0", er, rd);
        end
        transact(1'b1, 32'h2, 32'h66666666, 4'hF, 0, rd, er, lat, ac);
        transact(1'b0, 32'hFFC, 32'h0, 4'h0, 0, rd, er, lat, ac);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL last_word: got err=%b, need err=0", er);
        end
        transact(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, ac);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL word0_kept: got rdata=%h err=%b, need cafef00d err=0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic [31:0] rd0; logic er0;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        while (!resp_valid && w < 40) begin @(posedge clk); #1; w++; end
        rd0 = resp_rdata; er0 = resp_err;
        checks++;
        if (rd0 !== 32'hDEADBEEF || er0 !== 1'b0 || w !== LAT) begin
            errors++;
            $display("FAIL bp_first: got rdata=%h err=%b lat=%0d, need deadbeef err=0 lat=%0d", rd0, er0, w, LAT);
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'hF;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== rd0 || resp_err !== er0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: got vld=%b rdata=%h err=%b rdy=%b, need vld=1 rdata=%h err=%b rdy=0",
                         i, resp_valid, resp_rdata, resp_err, req_ready, rd0, er0);
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b vld=%b, need rdy=1 vld=0", req_ready, resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat, a0, a1;
        transact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, a0);
        transact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, a1);
        checks++;
        if (a1 - a0 !== LAT + 2) begin
            errors++;
            $display("FAIL throughput: got %0d cycles between accepts, need %0d", a1 - a0, LAT + 2);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat, ac;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== {3'b100, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid_wait: got rdy=%b vld=%b err=%b rdata=%h, need rdy=1 vld=0 err=0 rdata=0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        transact(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat, ac);
        checks++;
        if (rd !== 32'h12345678 || er !== 1'b0) begin
            errors++;
            $display("FAIL store_survives: got rdata=%h err=%b, need 12345678 err=0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] model [16];
        logic [31:0] rd, addr, wd, exp_rd;
        logic [3:0]  st;
        logic        er, we, exp_err;
        int          lat, ac, sel, idx;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            transact(1'b1, 32'h100 + 32'(4 * i), model[i], 4'hF, 0, rd, er, lat, ac);
        end
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 19);
            idx = $urandom_range(0, 15);
            addr = 32'h100 + 32'(4 * idx);
            if (sel < 3) addr = addr + 32'($urandom_range(1, 3));
            else if (sel < 6) addr = 32'h1000 + ($urandom & 32'h0FFF_FFFC);
            we = 1'($urandom);
            wd = $urandom;
            st = 4'($urandom);
            exp_err = (addr[1:0] != 2'b00) || (addr / 4 >= DEPTH);
            exp_rd = 32'h0;
            if (!exp_err && we) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
            end else if (!exp_err) begin
                exp_rd = model[idx];
            end
            transact(we, addr, wd, st, $urandom_range(0, 3), rd, er, lat, ac);
            checks++;
            if (rd !== exp_rd || er !== exp_err || lat !== LAT) begin
                errors++;
                $display("FAIL random%0d we=%b addr=%h: got rdata=%h err=%b lat=%0d, need rdata=%h err=%b lat=%0d",
                         n, we, addr, rd, er, lat, exp_rd, exp_err, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
